// File: rtl/soc_switch_debounce_if.sv
// Switch-debounce signal bundle: raw pins and event clear in, debounced levels and event status out.
interface soc_switch_debounce_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] event_clr;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] event_flags;
    logic             change_pulse;

    modport master (
        output sw_raw, event_clr,
        input  debounced, change_pulse, event_flags
    );

    modport slave (
        input  sw_raw, event_clr,
        output debounced, change_pulse, event_flags
    );
endinterface

// File: rtl/soc_switch_debounce.sv
// Two-flop synchronizer plus per-bit hold-time debounce for the slide switches.
// Sticky per-bit change flags are built only when SOC_SWITCH_DEBOUNCE_EVENT_EN is defined.
module soc_switch_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    soc_switch_debounce_if.slave bus
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] upd;
    logic             pulse;
    logic [CNT_W-1:0] cnt [WIDTH];

    // A bit accepts its new level on the edge its counter has already seen DEBOUNCE_CYCLES-1 differing cycles.
    always_comb begin
        upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i] = (sync2[i] != deb[i]) && (cnt[i] == TERM);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            pulse <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= bus.sw_raw;
            sync2 <= sync1;
            pulse <= |upd;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (upd[i]) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.debounced    = deb;
    assign bus.change_pulse = pulse;

`ifdef SOC_SWITCH_DEBOUNCE_EVENT_EN
    logic [WIDTH-1:0] flags;

    // Set is OR-ed in after the clear so a coincident event is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
        end else begin
            flags <= (flags & ~bus.event_clr) | upd;
        end
    end

    assign bus.event_flags = flags;
`else
    logic [WIDTH-1:0] unused_event_clr;
    assign unused_event_clr = bus.event_clr;
    assign bus.event_flags  = '0;
`endif
endmodule

// File: doc/soc_switch_debounce.md
# soc_switch_debounce

Synchronizes and debounces the ten raw slide-switch pins of the DE-series board before they reach the switches PIO's `in_port`. Each bit passes through a two-flop synchronizer and an independent hold-time counter, so the PIO only ever samples stable, glitch-free levels. The block also raises a one-cycle change strobe and, optionally, sticky per-bit change flags for software polling.

## Interface
- `WIDTH`, 10: number of switch bits.
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a new level must hold before it is accepted. The default is 10 ms at 50 MHz. Legal range is ≥1.
- `CNT_W`, 19: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES−1.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `sw_raw`  in  WIDTH  asynchronous switch pins.
- `debounced`  out  WIDTH  stable switch levels; drives the PIO `in_port`.
- `change_pulse`  out  1  one-cycle strobe when any `debounced` bit changes.
- `event_flags`  out  WIDTH  sticky per-bit change flags (see Configuration).
- `event_clr`  in  WIDTH  per-bit clear for `event_flags`; level-sensitive and sampled each cycle.

## Operation
- Synchronizer: `sync1 <= sw_raw`, `sync2 <= sync1`, per bit. There is no other use of `sw_raw`.
- Per-bit counter `cnt[i]`, CNT_W bits:
  - If `sync2[i] == debounced[i]`: `cnt[i] <= 0`.
  - Else, if `cnt[i] == DEBOUNCE_CYCLES−1`: `debounced[i] <= sync2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
- The counter never wraps: it is cleared on acceptance or on any return to the current level.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles leaves `debounced` untouched. A return to the old level at any count resets the count to 0.
- Bits are fully independent. Several bits may update on the same edge.
- `change_pulse` is registered and equals the OR of the per-bit update conditions on that edge. It is high in exactly the cycle in which the new `debounced` value is first visible.
- Event flags:
  - `event_flags[i]` is set on the same edge that `debounced[i]` changes, for both rising and falling changes.
  - It is cleared on an edge where `event_clr[i]=1`.
  - If set and clear coincide, set wins, so no event is lost.
- Reset: `sync1`, `sync2`, `cnt`, `debounced`, `change_pulse` and `event_flags` are all 0.
  - Switches held high through reset are accepted DEBOUNCE_CYCLES+2 cycles after reset release.
  - That acceptance produces the normal `change_pulse` and event flag.
- Reset asserted mid-count discards the count and any pending acceptance.

## Timing
- Let edge k be the first edge that samples a new stable `sw_raw[i]` level.
- `sync2[i]` holds the new level after edge k+1.
- Counting occurs on edges k+2 through k+1+DEBOUNCE_CYCLES.
- `debounced[i]` and `change_pulse` update on edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+1 cycles after edge k.
- `change_pulse` has width exactly 1 cycle per update edge. It is not stretched for back-to-back updates on consecutive edges from different bits; each such edge gives its own high cycle.
- `event_flags` has 1-cycle latency from `event_clr`.
- All outputs come directly from registers. No combinational path runs from `sw_raw` or `event_clr` to any output.

## Configuration
- Macro: `SOC_SWITCH_DEBOUNCE_EVENT_EN`.
- Defined: sticky `event_flags` logic and the `event_clr` handling are built as described above.
- Undefined:
  - `event_flags` is tied to constant 0.
  - `event_clr` is ignored.
  - No flag registers are synthesized.
  - `debounced` and `change_pulse` behaviour is identical in both builds.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `WIDTH`=10.
- Reset, all raw 0:
  - Stimulus: hold `reset` 3 cycles with `sw_raw`=0x000.
  - Required: all outputs 0 during reset and for 20 cycles after release.
  - Required: `change_pulse` never asserts.
- Clean press:
  - Stimulus: `sw_raw`=0x001 from edge k onward.
  - Required: `debounced`=0x001 and `change_pulse`=1 starting edge k+5.
  - Required: `change_pulse`=0 at edge k+6.
  - Required: `event_flags`=0x001 with the macro defined, 0x000 without it.
- Glitch rejection:
  - Stimulus: `sw_raw[3]` high for 3 cycles, then low.
  - Required: `debounced` stays 0x000 and `change_pulse` stays 0.
  - Stimulus: then high for 4+ cycles.
  - Required: bit 3 is accepted 5 edges after its first sampling.
- Simultaneous bits:
  - Stimulus: `sw_raw` from 0x000 to 0x3FF on one edge.
  - Required: all 10 bits update on the same edge, with a single 1-cycle `change_pulse`.
  - Stimulus: then back to 0x000.
  - Required: falling changes are also accepted after 5 edges.
- Event set/clear collision (macro defined):
  - Stimulus: hold `event_clr[0]`=1 continuously across a bit-0 acceptance edge.
  - Required: `event_flags[0]`=1 after that edge.
  - Required: `event_flags[0]`=0 one cycle later.
- Reset mid-count:
  - Stimulus: `sw_raw`=0x200 held, with `reset` pulsed after 3 counted cycles.
  - Required: `debounced` stays 0 through the pulse.
  - Required: acceptance occurs 5 edges after the first post-reset sampling of 0x200, not earlier.
